pin_entry: RTL and testbench

- Keypad-side front end for the lock. Turns raw Basys-style button presses into 4-digit BCD PINs.
- Presents each completed PIN to the PIN verifier as user_pin with a one-cycle valid_pin strobe.
- Owns the stored-PIN register. The register is rewritten when a PIN is completed while the verifier reports the adjustment state.
- Runs on the 500 Hz system tick.

---
 rtl/pin_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/pin_entry.sv | 142 ++++++++++++++
 tb/tb_pin_entry.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// Shared codes for the keypad PIN front end: verifier status, entry states, BCD limits.
// Constants and types only; no logic, no latency, no flow control.
package pin_pkg;

  localparam logic [1:0] ST_LOCKED = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  localparam logic [0:0] ENTRY = 1'b0;
  localparam logic [0:0] PULSE = 1'b1;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam int         NUM_DIGITS = 4;

  // One bit per keypad button, in the order the debouncer vector is packed.
  typedef struct packed {
    logic r;
    logic c;
    logic d;
    logic u;
  } btn_t;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to debounced level plus a one-cycle rise pulse.
// Pulse appears DEBOUNCE_LEN+1 edges after the first high sample; no backpressure.
module btn_debounce
  import pin_pkg::*;
#(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic [DEBOUNCE_LEN-1:0] samp_q, samp_d;
  logic                    level_q, level_d;
  logic                    rise_q;

  always_comb begin
    samp_d  = {samp_q[DEBOUNCE_LEN-2:0], raw_i};
    level_d = level_q;
    if (&samp_q) begin
      level_d = 1'b1;
    end else if (~|samp_q) begin
      level_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pin_entry.sv
// Keypad front end: debounced U/D/C/R presses build a 4-digit BCD PIN, strobed out with valid_pin.
// Final commit to valid_pin is one cycle; presses are never queued, lower-priority ones are dropped.
module pin_entry
  import pin_pkg::*;
#(
  parameter int          DEBOUNCE_LEN   = 4,
  parameter int          TIMEOUT_CYCLES = 2500,
  parameter logic [15:0] DEFAULT_PIN    = 16'h1234
) (
  input  logic        clk_500Hz,
  input  logic        rst,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnC,
  input  logic        btnR,
  input  logic [1:0]  status,
  output logic [15:0] user_pin,
  output logic        valid_pin,
  output logic [15:0] stored_pin,
  output logic [1:0]  digit_idx,
  output logic [3:0]  cur_digit
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_rise;
  logic [3:0] btn_lvl_unused;
  btn_t       rise;

  assign btn_raw = {btnR, btnC, btnD, btnU};
  assign rise    = btn_t'(btn_rise);

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .clk_i   (clk_500Hz),
      .rst_i   (rst),
      .raw_i   (btn_raw[i]),
      .level_o (btn_lvl_unused[i]),
      .rise_o  (btn_rise[i])
    );
  end

  logic [0:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    cur_q, cur_d;
  logic [11:0]   shift_q, shift_d;
  logic [15:0]   user_q, user_d;
  logic [15:0]   stored_q, stored_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic live, do_c, do_r, do_u, do_d, accepted;

  // Priority C > R > U/D; U and D together cancel each other.
  always_comb begin
    live     = (state_q == ENTRY) && (status != ST_OPEN);
    do_c     = live & rise.c;
    do_r     = live & ~rise.c & rise.r;
    do_u     = live & ~rise.c & ~rise.r & rise.u & ~rise.d;
    do_d     = live & ~rise.c & ~rise.r & rise.d & ~rise.u;
    accepted = do_c | do_r | do_u | do_d;
  end

  always_comb begin
    state_d  = ENTRY;
    idx_d    = idx_q;
    cur_d    = cur_q;
    shift_d  = shift_q;
    user_d   = user_q;
    stored_d = stored_q;

    if (status == ST_OPEN) begin
      idx_d   = 2'd0;
      cur_d   = 4'd0;
      shift_d = '0;
    end else if (do_c) begin
      cur_d = 4'd0;
      if (idx_q == 2'(NUM_DIGITS - 1)) begin
        user_d = {shift_q, cur_q};
        if (status == ST_ADJUST) begin
          stored_d = {shift_q, cur_q};
        end
        idx_d   = 2'd0;
        shift_d = '0;
        state_d = PULSE;
      end else begin
        shift_d = {shift_q[7:0], cur_q};
        idx_d   = idx_q + 2'd1;
      end
    end else if (do_r) begin
      cur_d = 4'd0;
      if (idx_q != 2'd0) begin
        idx_d   = idx_q - 2'd1;
        shift_d = shift_q >> 4;
      end
    end else if (do_u) begin
      cur_d = bcd_inc(cur_q);
    end else if (do_d) begin
      cur_d = bcd_dec(cur_q);
    end else if ((tmo_q == TMO_MAX) && ((idx_q != 2'd0) || (cur_q != 4'd0))) begin
      idx_d   = 2'd0;
      cur_d   = 4'd0;
      shift_d = '0;
    end

    if (accepted) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state_q  <= ENTRY;
      idx_q    <= 2'd0;
      cur_q    <= 4'd0;
      shift_q  <= '0;
      user_q   <= 16'h0000;
      stored_q <= DEFAULT_PIN;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
      shift_q  <= shift_d;
      user_q   <= user_d;
      stored_q <= stored_d;
      tmo_q    <= tmo_d;
    end
  end

  assign user_pin   = user_q;
  assign valid_pin  = (state_q == PULSE);
  assign stored_pin = stored_q;
  assign digit_idx  = idx_q;
  assign cur_digit  = cur_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed plus random keypad sessions against an action-level PIN model.
module tb_pin_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnU, btnD, btnC, btnR;
  logic [1:0]  status;
  logic [15:0] user_pin;
  logic        valid_pin;
  logic [15:0] stored_pin;
  logic [1:0]  digit_idx;
  logic [3:0]  cur_digit;

  always #5 clk = ~clk;

  pin_entry dut (
    .clk_500Hz  (clk),
    .rst        (rst),
    .btnU       (btnU),
    .btnD       (btnD),
    .btnC       (btnC),
    .btnR       (btnR),
    .status     (status),
    .user_pin   (user_pin),
    .valid_pin  (valid_pin),
    .stored_pin (stored_pin),
    .digit_idx  (digit_idx),
    .cur_digit  (cur_digit)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: committed digits as a list, PINs by place-value arithmetic.
  int m_d[$];
  int m_cur;
  int m_user;
  int m_stored;
  int m_status;

  int          pulses;
  logic [15:0] cap_user;
  logic [15:0] cap_stored;

  localparam logic [3:0] K_U = 4'b0001;
  localparam logic [3:0] K_D = 4'b0010;
  localparam logic [3:0] K_C = 4'b0100;
  localparam logic [3:0] K_R = 4'b1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (valid_pin === 1'b1) begin
      pulses++;
      cap_user   = user_pin;
      cap_stored = stored_pin;
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {btnR, btnC, btnD, btnU} = m;
  endtask

  task automatic model_reset();
    m_d.delete();
    m_cur    = 0;
    m_user   = 0;
    m_stored = 16'h1234;
  endtask

  task automatic model_press(input logic [3:0] m, output bit pulse_exp);
    pulse_exp = 1'b0;
    if (m_status == 1) return;
    if (m[2]) begin
      if (m_d.size() < 3) begin
        m_d.push_back(m_cur);
      end else begin
        m_user = m_d[0] * 4096 + m_d[1] * 256 + m_d[2] * 16 + m_cur;
        if (m_status == 2) m_stored = m_user;
        m_d.delete();
        pulse_exp = 1'b1;
      end
      m_cur = 0;
    end else if (m[3]) begin
      if (m_d.size() > 0) void'(m_d.pop_back());
      m_cur = 0;
    end else if (m[0] && !m[1]) begin
      m_cur = (m_cur + 1) % 10;
    end else if (m[1] && !m[0]) begin
      m_cur = (m_cur + 9) % 10;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " digit_idx"}, 32'(digit_idx), 32'(m_d.size()));
    check({tag, " cur_digit"}, 32'(cur_digit), 32'(m_cur));
    check({tag, " user_pin"}, 32'(user_pin), 32'(m_user));
    check({tag, " stored_pin"}, 32'(stored_pin), 32'(m_stored));
  endtask

  task automatic press(input logic [3:0] m, input string tag);
    bit pe;
    pulses = 0;
    drive(m);
    repeat (8) tick();
    drive(4'b0000);
    repeat (8) tick();
    model_press(m, pe);
    check({tag, " strobes"}, 32'(pulses), pe ? 32'd1 : 32'd0);
    if (pe) begin
      check({tag, " user@strobe"}, 32'(cap_user), 32'(m_user));
      check({tag, " stored@strobe"}, 32'(cap_stored), 32'(m_stored));
    end
    check_state(tag);
  endtask

  task automatic enter_digit(input int v, input string tag);
    repeat (v) press(K_U, {tag, " up"});
    press(K_C, {tag, " commit"});
  endtask

  task automatic set_status(input logic [1:0] s);
    status   = s;
    m_status = int'(s);
    if (s == 2'd1) begin
      m_d.delete();
      m_cur = 0;
    end
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000);
    status   = 2'd0;
    m_status = 0;
    model_reset();
    #12;
    check_state("reset");
    check("reset valid_pin", 32'(valid_pin), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check_state("after reset release");

    // PIN 1234 while locked: strobe, stored_pin unchanged.
    enter_digit(1, "p1234 d0");
    enter_digit(2, "p1234 d1");
    enter_digit(3, "p1234 d2");
    enter_digit(4, "p1234 d3");

    // Digit wrap both directions.
    press(K_D, "wrap down");
    press(K_U, "wrap up");
    for (int i = 0; i < 10; i++) press(K_U, "ten ups");

    // Adjust mode rewrites stored_pin; locked mode does not.
    set_status(2'd2);
    enter_digit(5, "adj");
    enter_digit(6, "adj");
    enter_digit(7, "adj");
    enter_digit(8, "adj");
    set_status(2'd0);
    enter_digit(4, "lock");
    enter_digit(3, "lock");
    enter_digit(2, "lock");
    enter_digit(1, "lock");

    // Backspace then finish as 1999.
    enter_digit(1, "bs");
    enter_digit(2, "bs");
    press(K_R, "bs back");
    enter_digit(9, "bs");
    enter_digit(9, "bs");
    enter_digit(9, "bs");

    // Idle timeout discards a partial entry just after the limit.
    enter_digit(3, "tmo");
    press(K_U, "tmo");
    pulses = 0;
    repeat (2470) tick();
    check_state("tmo before limit");
    repeat (40) tick();
    m_d.delete();
    m_cur = 0;
    check_state("tmo after limit");
    check("tmo strobes", 32'(pulses), 32'd0);

    // Open: presses ignored, entry held clear.
    press(K_U, "pre-open");
    set_status(2'd1);
    press(K_U, "open up");
    press(K_C, "open commit");
    set_status(2'd0);

    // Glitches must not register as presses.
    press(K_U, "pre-glitch");
    repeat (6) begin
      btnU = 1'b1; tick();
      btnU = 1'b0; tick();
    end
    repeat (6) begin
      btnU = 1'b1; repeat (3) tick();
      btnU = 1'b0; tick();
    end
    repeat (8) tick();
    check_state("glitch");

    // Simultaneous C and U: commit only.
    press(K_C | K_U, "c+u");
    press(K_U | K_D, "u+d");
    press(K_R | K_U, "r+u");

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35)      press(K_U, "rnd U");
      else if (r < 50) press(K_D, "rnd D");
      else if (r < 75) press(K_C, "rnd C");
      else if (r < 85) press(K_R, "rnd R");
      else if (r < 90) press(4'($urandom_range(0, 15)), "rnd combo");
      else if ($urandom_range(0, 9) < 2) set_status(2'd1);
      else set_status($urandom_range(0, 1) != 0 ? 2'd2 : 2'd0);
    end

    // Async reset mid-entry restores everything, including stored_pin.
    set_status(2'd2);
    enter_digit(8, "pre-rst");
    enter_digit(8, "pre-rst");
    enter_digit(8, "pre-rst");
    enter_digit(8, "pre-rst");
    enter_digit(2, "pre-rst partial");
    press(K_U, "pre-rst partial");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("async rst");
    check("async rst valid_pin", 32'(valid_pin), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_status(2'd0);
    press(K_U, "post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
